// File: rtl/trig_lv1a_merge_if.sv
// Trigger-path bundle between the LV1A merge stage and its neighbours:
// per-type lv1a pulses in, global LV1A with its tags and the busy flag out.
interface trig_lv1a_merge_if #(
    parameter int unsigned NTYPE = 8,
    parameter int unsigned CNT_W = 32
);
    logic [NTYPE-1:0] in_lv1a;
    logic             out_lv1a;
    logic [NTYPE-1:0] out_type;
    logic [CNT_W-1:0] out_trig_num;
    logic             busy;

    modport master (
        output in_lv1a,
        input  out_lv1a, out_type, out_trig_num, busy
    );

    modport slave (
        input  in_lv1a,
        output out_lv1a, out_type, out_trig_num, busy
    );
endinterface

// File: rtl/trig_lv1a_merge.sv
// Merges per-type LV1A pulses into one prescaled, tagged global LV1A with run statistics.
// Deadtime (DEAD state, dt_cnt, n_lost, busy) is built only when LV1A_DEADTIME_EN is defined.
module trig_lv1a_merge #(
    parameter int unsigned NTYPE = 8,
    parameter int unsigned PS_W  = 16,
    parameter int unsigned DT_W  = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_live,
    input  logic                  in_ena,
    input  logic [NTYPE-1:0]      user_mask,
    input  logic [NTYPE*PS_W-1:0] prescale,
    input  logic [DT_W-1:0]       deadtime,
    output logic [CNT_W-1:0]      n_req,
    output logic [CNT_W-1:0]      n_acc,
    output logic [CNT_W-1:0]      n_lost,
    trig_lv1a_merge_if.slave      bus
);

    logic [NTYPE-1:0] req;
    logic [NTYPE-1:0] pass;
    logic             any_pass;
    logic             issue;
    logic             lost;
    logic             busy;
    logic             pre_live_q;
    logic             live_rise;

    assign live_rise = in_live & ~pre_live_q;
    assign any_pass  = |pass;

    for (genvar i = 0; i < NTYPE; i++) begin : g_type
        logic [PS_W-1:0] ps_val;
        logic [PS_W-1:0] ps_cnt_q;

        assign ps_val  = prescale[i*PS_W +: PS_W];
        assign req[i]  = bus.in_lv1a[i] & user_mask[i] & in_ena & in_live;
        // >= lets a prescale lowered below the running count pass on the next request
        assign pass[i] = req[i] && (ps_val != '0) && (ps_cnt_q >= ps_val - 1'b1);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ps_cnt_q <= '0;
            end else if (!in_live || pass[i]) begin
                ps_cnt_q <= '0;
            end else if (req[i]) begin
                ps_cnt_q <= ps_cnt_q + 1'b1;
            end
        end
    end

`ifdef LV1A_DEADTIME_EN
    typedef enum logic {StIdle, StDead} state_e;

    state_e          state_q, state_d;
    logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            dt_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            dt_cnt_q <= dt_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        if (!in_live) begin
            state_d  = StIdle;
            dt_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_pass && (deadtime != '0)) begin
                        state_d  = StDead;
                        dt_cnt_d = deadtime;
                    end
                end
                StDead: begin
                    dt_cnt_d = dt_cnt_q - 1'b1;
                    if (dt_cnt_q <= DT_W'(1)) begin
                        state_d  = StIdle;
                        dt_cnt_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        issue = 1'b0;
        lost  = 1'b0;
        busy  = 1'b0;
        unique case (state_q)
            StIdle: issue = any_pass;
            StDead: begin
                lost = any_pass;
                busy = 1'b1;
            end
            default: ;
        endcase
    end
`else
    logic unused_deadtime;

    assign unused_deadtime = ^deadtime;
    assign issue           = any_pass;
    assign lost            = 1'b0;
    assign busy            = 1'b0;
`endif

    logic [CNT_W-1:0] n_req_q, n_req_d;
    logic [CNT_W-1:0] n_acc_q, n_acc_d;
    logic [CNT_W-1:0] n_lost_q, n_lost_d;
    logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
    logic [CNT_W-1:0] trig_num_q, trig_num_d;
    logic [NTYPE-1:0] type_q, type_d;
    logic             lv1a_q, lv1a_d;

    // A live rising edge clears first; a request in the same cycle then counts on top.
    always_comb begin
        n_req_d    = live_rise ? '0 : n_req_q;
        n_acc_d    = live_rise ? '0 : n_acc_q;
        n_lost_d   = live_rise ? '0 : n_lost_q;
        trig_cnt_d = live_rise ? '0 : trig_cnt_q;
        trig_num_d = live_rise ? '0 : trig_num_q;
        type_d     = live_rise ? '0 : type_q;
        lv1a_d     = 1'b0;

        if ((|req) && (n_req_d != '1)) begin
            n_req_d = n_req_d + 1'b1;
        end
        if (issue) begin
            lv1a_d     = 1'b1;
            type_d     = pass;
            trig_num_d = trig_cnt_d;
            trig_cnt_d = trig_cnt_d + 1'b1;
            if (n_acc_d != '1) begin
                n_acc_d = n_acc_d + 1'b1;
            end
        end
        if (lost && (n_lost_d != '1)) begin
            n_lost_d = n_lost_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_live_q <= 1'b0;
            n_req_q    <= '0;
            n_acc_q    <= '0;
            n_lost_q   <= '0;
            trig_cnt_q <= '0;
            trig_num_q <= '0;
            type_q     <= '0;
            lv1a_q     <= 1'b0;
        end else begin
            pre_live_q <= in_live;
            n_req_q    <= n_req_d;
            n_acc_q    <= n_acc_d;
            n_lost_q   <= n_lost_d;
            trig_cnt_q <= trig_cnt_d;
            trig_num_q <= trig_num_d;
            type_q     <= type_d;
            lv1a_q     <= lv1a_d;
        end
    end

    assign bus.out_lv1a     = lv1a_q;
    assign bus.out_type     = type_q;
    assign bus.out_trig_num = trig_num_q;
    assign bus.busy         = busy;
    assign n_req            = n_req_q;
    assign n_acc            = n_acc_q;
    assign n_lost           = n_lost_q;

endmodule

// File: tb/tb_trig_lv1a_merge.sv
// Scoreboard bench for trig_lv1a_merge: expected LV1As are queued as stimulus is driven
// and matched (cycle, type, number) when the DUT pulses out_lv1a.
module tb_trig_lv1a_merge;
    localparam int unsigned NTYPE = 8;
    localparam int unsigned PS_W  = 16;
    localparam int unsigned DT_W  = 8;
    localparam int unsigned CNT_W = 32;
`ifdef LV1A_DEADTIME_EN
    localparam bit DtEn = 1'b1;
`else
    localparam bit DtEn = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  in_live;
    logic                  in_ena;
    logic [NTYPE-1:0]      user_mask;
    logic [NTYPE*PS_W-1:0] prescale;
    logic [DT_W-1:0]       deadtime;
    logic [CNT_W-1:0]      n_req;
    logic [CNT_W-1:0]      n_acc;
    logic [CNT_W-1:0]      n_lost;

    trig_lv1a_merge_if #(.NTYPE(NTYPE), .CNT_W(CNT_W)) bus ();

    trig_lv1a_merge #(
        .NTYPE(NTYPE),
        .PS_W (PS_W),
        .DT_W (DT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_live  (in_live),
        .in_ena   (in_ena),
        .user_mask(user_mask),
        .prescale (prescale),
        .deadtime (deadtime),
        .n_req    (n_req),
        .n_acc    (n_acc),
        .n_lost   (n_lost),
        .bus      (bus)
    );

    typedef struct {
        longint           cyc;
        logic [NTYPE-1:0] typ;
        logic [CNT_W-1:0] num;
    } exp_t;

    exp_t             sb[$];
    longint           cyc = 0;
    logic [CNT_W-1:0] trig_exp;
    int               n_checks = 0;
    int               n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_lv1a) begin
            if (sb.size() == 0) begin
                check("unexpected_lv1a", 64'(bus.out_lv1a), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("lv1a_cycle", cyc, e.cyc);
                check("lv1a_type", 64'(bus.out_type), 64'(e.typ));
                check("lv1a_num", 64'(bus.out_trig_num), 64'(e.num));
            end
        end
    end

    // One clock of stimulus; an expected issue lands one cycle later.
    task automatic drive(input logic [NTYPE-1:0] lv1a, input bit exp_issue,
                         input logic [NTYPE-1:0] exp_type);
        exp_t e;
        bus.in_lv1a = lv1a;
        if (exp_issue) begin
            e.cyc = cyc + 1;
            e.typ = exp_type;
            e.num = trig_exp;
            sb.push_back(e);
            trig_exp++;
        end
        @(posedge clk);
        #1;
        bus.in_lv1a = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, 1'b0, '0);
    endtask

    task automatic set_ps(input int i, input logic [PS_W-1:0] v);
        prescale[i*PS_W +: PS_W] = v;
    endtask

    task automatic relive();
        in_live = 1'b0;
        idle(2);
        in_live  = 1'b1;
        trig_exp = '0;
        idle(1);
    endtask

    task automatic end_scn();
        idle(3);
        check("sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        rst         = 1'b1;
        in_live     = 1'b0;
        in_ena      = 1'b1;
        user_mask   = '0;
        prescale    = '0;
        deadtime    = '0;
        bus.in_lv1a = '0;
        trig_exp    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lv1a", 64'(bus.out_lv1a), 64'd0);
        check("rst_type", 64'(bus.out_type), 64'd0);
        check("rst_num", 64'(bus.out_trig_num), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_n_req", 64'(n_req), 64'd0);
        check("rst_n_acc", 64'(n_acc), 64'd0);
        check("rst_n_lost", 64'(n_lost), 64'd0);
        rst = 1'b0;
        idle(2);

        // Live rising edge with a request in the same cycle
        user_mask = 8'h01;
        set_ps(0, 16'd1);
        in_live   = 1'b1;
        trig_exp  = '0;
        drive(8'h01, 1'b1, 8'h01);
        idle(2);
        check("s2_n_acc", 64'(n_acc), 64'd1);
        check("s2_n_req", 64'(n_req), 64'd1);
        check("s2_type", 64'(bus.out_type), 64'h01);
        check("s2_num", 64'(bus.out_trig_num), 64'd0);
        end_scn();

        // Statistics hold while not live, clear on the rising edge
        in_live = 1'b0;
        drive(8'h01, 1'b0, '0);
        idle(2);
        check("hold_n_acc", 64'(n_acc), 64'd1);
        check("hold_n_req", 64'(n_req), 64'd1);
        check("hold_type", 64'(bus.out_type), 64'h01);
        in_live  = 1'b1;
        trig_exp = '0;
        idle(1);
        check("clr_n_acc", 64'(n_acc), 64'd0);
        check("clr_n_req", 64'(n_req), 64'd0);
        check("clr_type", 64'(bus.out_type), 64'd0);

        // Prescale 3 on type 2
        user_mask = 8'h04;
        set_ps(2, 16'd3);
        for (int k = 1; k <= 9; k++) begin
            drive(8'h04, (k % 3) == 0, 8'h04);
            idle(19);
        end
        check("s3_n_req", 64'(n_req), 64'd9);
        check("s3_n_acc", 64'(n_acc), 64'd3);
        check("s3_num", 64'(bus.out_trig_num), 64'd2);
        end_scn();

        // Deadtime 4 against a continuous request stream
        relive();
        deadtime  = 8'd4;
        user_mask = 8'h01;
        for (int i = 0; i < 10; i++) begin
            drive(8'h01, !DtEn || i == 0 || i == 5, 8'h01);
            check("s4_busy", 64'(bus.busy),
                  64'(DtEn && ((i <= 3) || (i >= 5 && i <= 8))));
        end
        check("s4_n_req", 64'(n_req), 64'd10);
        check("s4_n_acc", 64'(n_acc), DtEn ? 64'd2 : 64'd10);
        check("s4_n_lost", 64'(n_lost), DtEn ? 64'd8 : 64'd0);
        end_scn();

        // Two types in one cycle, then back-to-back; in_ena gates requests
        relive();
        deadtime  = '0;
        user_mask = 8'h0A;
        set_ps(1, 16'd1);
        set_ps(3, 16'd1);
        in_ena = 1'b0;
        drive(8'h0A, 1'b0, '0);
        in_ena = 1'b1;
        drive(8'h0B, 1'b1, 8'h0A);
        drive(8'h08, 1'b1, 8'h08);
        idle(1);
        check("s5_n_acc", 64'(n_acc), 64'd2);
        check("s5_n_req", 64'(n_req), 64'd2);
        check("s5_type", 64'(bus.out_type), 64'h08);
        check("s5_num", 64'(bus.out_trig_num), 64'd1);
        end_scn();

        // Live dropped during DEAD with requests pending
        relive();
        deadtime  = 8'd10;
        user_mask = 8'h01;
        drive(8'h01, 1'b1, 8'h01);
        drive(8'h01, !DtEn, 8'h01);
        drive(8'h01, !DtEn, 8'h01);
        in_live = 1'b0;
        for (int k = 0; k < 3; k++) drive(8'h01, 1'b0, '0);
        check("s6_busy", 64'(bus.busy), 64'd0);
        check("s6_n_req", 64'(n_req), 64'd3);
        check("s6_n_acc", 64'(n_acc), DtEn ? 64'd1 : 64'd3);
        check("s6_n_lost", 64'(n_lost), DtEn ? 64'd2 : 64'd0);
        check("s6_num", 64'(bus.out_trig_num), DtEn ? 64'd0 : 64'd2);
        in_live  = 1'b1;
        trig_exp = '0;
        drive(8'h01, 1'b1, 8'h01);
        idle(1);
        check("s6_relive_n_req", 64'(n_req), 64'd1);
        check("s6_relive_n_acc", 64'(n_acc), 64'd1);
        check("s6_relive_n_lost", 64'(n_lost), 64'd0);
        end_scn();

        // Asynchronous reset mid-run drops the pending LV1A
        relive();
        deadtime  = '0;
        user_mask = 8'h01;
        drive(8'h01, 1'b1, 8'h01);
        drive(8'h01, 1'b1, 8'h01);
        #5;
        bus.in_lv1a = 8'h01;
        #1;
        rst = 1'b1;
        #1;
        check("s1_lv1a", 64'(bus.out_lv1a), 64'd0);
        check("s1_type", 64'(bus.out_type), 64'd0);
        check("s1_num", 64'(bus.out_trig_num), 64'd0);
        check("s1_n_req", 64'(n_req), 64'd0);
        check("s1_n_acc", 64'(n_acc), 64'd0);
        check("s1_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        bus.in_lv1a = '0;
        check("s1_held_n_req", 64'(n_req), 64'd0);
        rst      = 1'b0;
        trig_exp = '0;
        drive(8'h01, 1'b1, 8'h01);
        idle(1);
        check("s1_post_n_acc", 64'(n_acc), 64'd1);
        check("s1_post_n_req", 64'(n_req), 64'd1);
        end_scn();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
